vc_iter_muldiv_unit: RTL and testbench

- Parametrised, multi-cycle radix-2 iterative multiply/divide unit.
- Successor to the single-cycle arithmetic primitives; lives in the datapath library beside them.
- Serves the processor execute stage through val/rdy request/response ports.
- Carries the SecVerilog security domain of each request through to its response.

---
 rtl/vc_muldiv_pkg.sv | 18 +
 rtl/vc_Subtractor.sv | 13 +
 rtl/vc_iter_muldiv_dpath.sv | 78 +++++++
 rtl/vc_iter_muldiv_unit.sv | 99 +++++++++
 tb/tb_vc_iter_muldiv_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vc_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
// No logic here; no latency and no flow control.
package vc_muldiv_pkg;

  typedef enum logic [1:0] {
    VC_MULDIV_OP_MUL  = 2'b00,
    VC_MULDIV_OP_DIVU = 2'b01,
    VC_MULDIV_OP_REMU = 2'b10,
    VC_MULDIV_OP_RSVD = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/vc_Subtractor.sv
// Combinational two's-complement subtractor, out = in0 - in1 modulo 2^p_nbits.
// Zero latency; no flow control.
module vc_Subtractor #(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out
);

  assign out = in0 - in1;

endmodule

// File: rtl/vc_iter_muldiv_dpath.sv
// Operand, accumulator and remainder registers for one radix-2 step per cycle.
// One iteration per asserted step; no flow control, sequencing comes from the FSM.
module vc_iter_muldiv_dpath
  import vc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  muldiv_op_e         op,
  input  logic [p_nbits-1:0] a_in,
  input  logic [p_nbits-1:0] b_in,
  output logic [p_nbits-1:0] result,
  output logic               borrow
);

  // a_reg: multiplicand for MUL, dividend/quotient shift register for DIV.
  // b_reg: multiplier for MUL, divisor for DIV.  acc_reg: product or remainder.
  logic [p_nbits-1:0] a_reg;
  logic [p_nbits-1:0] b_reg;
  logic [p_nbits-1:0] acc_reg;

  logic [p_nbits-1:0] mul_sum;
  logic [p_nbits:0]   rem_sh;
  logic [p_nbits:0]   diff;

  assign mul_sum = acc_reg + a_reg;
  assign rem_sh  = {acc_reg, a_reg[p_nbits-1]};

  vc_Subtractor #(.p_nbits(p_nbits+1)) sub (
    .in0 (rem_sh),
    .in1 ({1'b0, b_reg}),
    .out (diff)
  );

  // A set top bit in the shifted remainder already exceeds any divisor.
  assign borrow = ~rem_sh[p_nbits] & diff[p_nbits];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (load) begin
      a_reg   <= a_in;
      b_reg   <= b_in;
      acc_reg <= '0;
    end else if (step) begin
      case (op)
        VC_MULDIV_OP_MUL: begin
          if (b_reg[0]) acc_reg <= mul_sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
        end
        VC_MULDIV_OP_DIVU, VC_MULDIV_OP_REMU: begin
          a_reg   <= {a_reg[p_nbits-2:0], ~borrow};
          acc_reg <= borrow ? rem_sh[p_nbits-1:0] : diff[p_nbits-1:0];
        end
        default: begin
          a_reg <= a_reg;
        end
      endcase
    end
  end

  always_comb begin
    result = '0;
    case (op)
      VC_MULDIV_OP_MUL:  result = acc_reg;
      VC_MULDIV_OP_DIVU: result = a_reg;
      VC_MULDIV_OP_REMU: result = acc_reg;
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/vc_iter_muldiv_unit.sv
// Iterative MUL/DIVU/REMU with domain tag; fixed p_nbits-cycle CALC, response p_nbits edges after accept.
// One op in flight: req_rdy only in IDLE; response held in DONE until resp_rdy.
module vc_iter_muldiv_unit
  import vc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [1:0]         req_op,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               req_domain,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               resp_domain
);

  localparam int p_cnt_nbits = $clog2(p_nbits) + 1;
  localparam logic [p_cnt_nbits-1:0] CNT_INIT = p_cnt_nbits'(p_nbits);
  localparam logic [p_cnt_nbits-1:0] CNT_ONE  = p_cnt_nbits'(1);

  muldiv_state_e            state;
  muldiv_state_e            state_next;
  logic [p_cnt_nbits-1:0]   cnt;
  logic [p_cnt_nbits-1:0]   cnt_next;
  muldiv_op_e               op_reg;
  logic                     dom_reg;
  logic                     load;
  logic                     step;
  logic [p_nbits-1:0]       dp_result;
  logic                     unused_borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_reg  <= VC_MULDIV_OP_MUL;
      dom_reg <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        op_reg  <= muldiv_op_e'(req_op);
        dom_reg <= req_domain;
      end
    end
  end

  // Counter never short-circuits: every op spends exactly p_nbits cycles in CALC.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    step       = 1'b0;
    req_rdy    = (state == IDLE);
    resp_val   = (state == DONE);
    case (state)
      IDLE: begin
        if (req_val) begin
          load       = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = CALC;
        end
      end
      CALC: begin
        step     = 1'b1;
        cnt_next = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_next = DONE;
      end
      DONE: begin
        if (resp_rdy) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  vc_iter_muldiv_dpath #(.p_nbits(p_nbits)) dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .op     (op_reg),
    .a_in   (req_a),
    .b_in   (req_b),
    .result (dp_result),
    .borrow (unused_borrow)
  );

  // Intermediate register contents never leave the unit before completion.
  assign resp_result = (state == DONE) ? dp_result : '0;
  assign resp_domain = dom_reg;

endmodule

// File: tb/tb_vc_iter_muldiv_unit.sv
// Bench for vc_iter_muldiv_unit at p_nbits=8: directed table, corner sequences, random ops vs model.
module tb_vc_iter_muldiv_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_val = 1'b0;
  logic       req_rdy;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic       req_domain = 1'b0;
  logic       resp_val;
  logic       resp_rdy = 1'b0;
  logic [7:0] resp_result;
  logic       resp_domain;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_iter_muldiv_unit #(.p_nbits(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_domain  (req_domain),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_result (resp_result),
    .resp_domain (resp_domain)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       dom;
    logic [7:0] exp;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia * ib;
      2'd1:    r = (ib == 0) ? 255 : ia / ib;
      2'd2:    r = (ib == 0) ? ia : ia % ib;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Starts at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic dom);
    int n;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_domain = dom;
    req_val    = 1'b1;
    n = 0;
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy_before_accept", 32'(req_rdy), 32'd1);
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  // Waits for the response, checks latency/result/domain, holds for 'hold' cycles, then hands it off.
  task automatic collect(input logic [7:0] exp, input logic dom, input int hold, input string name);
    int lat;
    logic quiet;
    logic stable;
    logic [7:0] r0;
    logic d0;
    quiet = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!resp_val && (resp_result !== 8'd0 || req_rdy !== 1'b0)) quiet = 1'b0;
    end while (!resp_val && lat < 40);
    check({name, "_latency"}, 32'(lat), 32'd8);
    check({name, "_result"}, 32'(resp_result), 32'(exp));
    check({name, "_domain"}, 32'(resp_domain), 32'(dom));
    check({name, "_calc_quiet"}, 32'(quiet), 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      r0 = resp_result;
      d0 = resp_domain;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (resp_result !== r0 || resp_domain !== d0 || resp_val !== 1'b1 || req_rdy !== 1'b0)
          stable = 1'b0;
      end
      check({name, "_hold_stable"}, 32'(stable), 32'd1);
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    check({name, "_resp_val_drop"}, 32'(resp_val), 32'd0);
    check({name, "_req_rdy_back"}, 32'(req_rdy), 32'd1);
  endtask

  initial begin
    vecs[0] = '{op: 2'd0, a: 8'd13,   b: 8'd11, dom: 1'b1, exp: 8'h8F, hold: 0};
    vecs[1] = '{op: 2'd0, a: 8'hFF,   b: 8'h02, dom: 1'b0, exp: 8'hFE, hold: 0};
    vecs[2] = '{op: 2'd1, a: 8'd100,  b: 8'd7,  dom: 1'b1, exp: 8'd14, hold: 0};
    vecs[3] = '{op: 2'd2, a: 8'd100,  b: 8'd7,  dom: 1'b0, exp: 8'd2,  hold: 0};
    vecs[4] = '{op: 2'd1, a: 8'h2A,   b: 8'd0,  dom: 1'b1, exp: 8'hFF, hold: 0};
    vecs[5] = '{op: 2'd2, a: 8'h2A,   b: 8'd0,  dom: 1'b0, exp: 8'h2A, hold: 0};
    vecs[6] = '{op: 2'd3, a: 8'h55,   b: 8'h33, dom: 1'b1, exp: 8'h00, hold: 0};
    vecs[7] = '{op: 2'd0, a: 8'd7,    b: 8'd9,  dom: 1'b1, exp: 8'h3F, hold: 5};

    #3;
    check("reset_req_rdy", 32'(req_rdy), 32'd1);
    check("reset_resp_val", 32'(resp_val), 32'd0);
    check("reset_resp_result", 32'(resp_result), 32'd0);
    check("reset_resp_domain", 32'(resp_domain), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dom);
      collect(vecs[i].exp, vecs[i].dom, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Second request presented mid-CALC waits for the first IDLE cycle.
    issue(2'd0, 8'd6, 8'd7, 1'b1);
    req_op     = 2'd1;
    req_a      = 8'd200;
    req_b      = 8'd9;
    req_domain = 1'b0;
    req_val    = 1'b1;
    collect(8'd42, 1'b1, 2, "busy_first");
    issue(2'd1, 8'd200, 8'd9, 1'b0);
    collect(8'd22, 1'b0, 0, "busy_second");

    // Reset pulse in the middle of CALC.
    issue(2'd0, 8'h12, 8'h34, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_resp_val", 32'(resp_val), 32'd0);
    check("midreset_req_rdy", 32'(req_rdy), 32'd1);
    check("midreset_resp_result", 32'(resp_result), 32'd0);
    check("midreset_resp_domain", 32'(resp_domain), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(2'd0, 8'd3, 8'd5, 1'b0);
    collect(8'd15, 1'b0, 0, "post_reset_mul");

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [7:0] a, b;
      logic dom;
      int hold;
      op   = 2'($urandom_range(0, 3));
      a    = 8'($urandom);
      b    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      dom  = 1'($urandom);
      hold = $urandom_range(0, 2);
      issue(op, a, b, dom);
      collect(model(op, a, b), dom, hold, $sformatf("rand%0d_op%0d_%0h_%0h", i, op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
